// File: rtl/pipeline_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pipeline_types (package)
// Brief  : Shared control bundle, controller state encoding and stage indices
// Rev    : 1.0
// ============================================================================
package pipeline_types;

    localparam int NUM_STAGES   = 6;

    localparam int STG_PC       = 0;
    localparam int STG_IF       = 1;
    localparam int STG_ID       = 2;
    localparam int STG_DISPATCH = 3;
    localparam int STG_EX       = 4;
    localparam int STG_MEM      = 5;

    typedef struct packed {
        logic [NUM_STAGES-1:0] pause;
        logic                  exception_flush;
        logic                  branch_flush;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH      = 2'd2,
        IDLE_WAIT  = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pause_merge
// Brief  : Suffix-OR of stall requests: a stall in stage k freezes stages 0..k
// Rev    : 1.0
// ============================================================================
module pause_merge #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] pause_req_i,
    output logic [STAGES-1:0] pause_o
);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_suffix_or
        assign pause_o[gi] = |pause_req_i[STAGES-1:gi];
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Pipeline pause/flush controller with redirect sequencing and watchdog
// Rev    : 1.0
// ============================================================================
module pipeline_ctrl
    import pipeline_types::*;
#(
    parameter int STAGES        = NUM_STAGES,
    parameter int PC_W          = 32,
    parameter int PAUSE_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] pause_req,
    input  logic              mem_busy,
    input  logic              excp_valid,
    input  logic [PC_W-1:0]   excp_target,
    input  logic              branch_valid,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              idle_valid,
    input  logic              irq_pending,
    output ctrl_t             ctrl,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(PAUSE_TIMEOUT);

    ctrl_state_e       state_q, state_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
    logic              redir_v_q, redir_v_d;
    logic              exc_flush_q, exc_flush_d;
    logic              br_flush_q, br_flush_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              err_q, err_d;

    logic [STAGES-1:0] w_merged;
    logic [STAGES-1:0] w_pause;
    logic              w_br_accept;

    pause_merge #(
        .STAGES (STAGES)
    ) u_pause_merge (
        .pause_req_i (pause_req),
        .pause_o     (w_merged)
    );

    // Pause is combinational, so it is forced low while reset is held.
    always_comb begin
        w_pause = '0;
        if (rst) begin
            case (state_q)
                RUN:                   w_pause = w_merged;
                FLUSH_WAIT, IDLE_WAIT: w_pause = '1;
                default:               w_pause = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        w_br_accept = 1'b0;
        case (state_q)
            RUN: begin
                if (excp_valid) begin
                    target_d = excp_target;
                    state_d  = mem_busy ? FLUSH_WAIT : FLUSH;
                end else begin
                    w_br_accept = branch_valid && !w_pause[STG_EX];
                    if (idle_valid && !irq_pending) state_d = IDLE_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!mem_busy) state_d = FLUSH;
            end
            FLUSH: state_d = RUN;
            IDLE_WAIT: begin
                if (excp_valid) begin
                    target_d = excp_target;
                    state_d  = mem_busy ? FLUSH_WAIT : FLUSH;
                end else if (irq_pending) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Flush/redirect pulses are registered so they line up with the FLUSH state.
    always_comb begin
        exc_flush_d = 1'b0;
        br_flush_d  = 1'b0;
        redir_v_d   = 1'b0;
        redir_pc_d  = redir_pc_q;
        if (state_d == FLUSH) begin
            exc_flush_d = 1'b1;
            redir_v_d   = 1'b1;
            redir_pc_d  = target_d;
        end else if (w_br_accept) begin
            br_flush_d  = 1'b1;
            redir_v_d   = 1'b1;
            redir_pc_d  = branch_target;
        end
    end

    always_comb begin
        wdog_d = '0;
        if (w_pause[STAGES-1]) begin
            wdog_d = (wdog_q == C_TIMEOUT) ? wdog_q : wdog_q + 1'b1;
        end
        err_d = err_q | (wdog_d == C_TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            target_q    <= '0;
            redir_pc_q  <= '0;
            redir_v_q   <= 1'b0;
            exc_flush_q <= 1'b0;
            br_flush_q  <= 1'b0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            redir_pc_q  <= redir_pc_d;
            redir_v_q   <= redir_v_d;
            exc_flush_q <= exc_flush_d;
            br_flush_q  <= br_flush_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
        end
    end

    assign ctrl = '{pause: w_pause, exception_flush: exc_flush_q, branch_flush: br_flush_q};
    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;
    assign timeout_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_pipeline_ctrl
// Brief  : Directed scoreboard bench for pipeline_ctrl
// Rev    : 1.0
// ============================================================================
module tb_pipeline_ctrl;
    import pipeline_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pause_req;
    logic        mem_busy, excp_valid, branch_valid, idle_valid, irq_pending;
    logic [31:0] excp_target, branch_target;
    ctrl_t       ctrl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        timeout_err;

    typedef struct {
        int          due;
        bit          is_exc;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_asrt  = 0;
    int   n_fail  = 0;

    pipeline_ctrl #(
        .STAGES(6), .PC_W(32), .PAUSE_TIMEOUT(1024), .CNT_W(11)
    ) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .mem_busy(mem_busy),
        .excp_valid(excp_valid), .excp_target(excp_target),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .idle_valid(idle_valid), .irq_pending(irq_pending), .ctrl(ctrl),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        chk("flush_exclusive", {63'd0, ctrl.exception_flush & ctrl.branch_flush}, 64'd0);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("exc_flush",   {63'd0, ctrl.exception_flush}, {63'd0, e.is_exc});
            chk("br_flush",    {63'd0, ctrl.branch_flush},    {63'd0, !e.is_exc});
            chk("redir_valid", {63'd0, redirect_valid},       64'd1);
            chk("redir_pc",    {32'd0, redirect_pc},          {32'd0, e.pc});
        end else begin
            chk("no_flush", {61'd0, ctrl.exception_flush, ctrl.branch_flush, redirect_valid}, 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic push(input int due, input bit is_exc, input logic [31:0] pc);
        exp_t e;
        e.due = due; e.is_exc = is_exc; e.pc = pc;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; pause_req = 6'b000100; mem_busy = 0; excp_valid = 0;
        branch_valid = 0; idle_valid = 0; irq_pending = 0;
        excp_target = '0; branch_target = '0;
        #1;
        chk("rst_pause",      {58'd0, ctrl.pause}, 64'd0);
        chk("rst_exc_flush",  {63'd0, ctrl.exception_flush}, 64'd0);
        chk("rst_br_flush",   {63'd0, ctrl.branch_flush}, 64'd0);
        chk("rst_redir_v",    {63'd0, redirect_valid}, 64'd0);
        chk("rst_redir_pc",   {32'd0, redirect_pc}, 64'd0);
        chk("rst_timeout",    {63'd0, timeout_err}, 64'd0);
        pause_req = '0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Stall propagation
        pause_req = 6'b000100; #1;
        chk("stall_stage2", {58'd0, ctrl.pause}, 64'b000111);
        pause_req = 6'b100000; #1;
        chk("stall_stage5", {58'd0, ctrl.pause}, 64'b111111);
        pause_req = '0;
        tick();

        // Direct exception
        excp_valid = 1; excp_target = 32'h1C00_0100;
        push(cyc + 1, 1'b1, 32'h1C00_0100);
        tick();
        excp_valid = 0; pause_req = 6'b000001; #1;
        chk("flush_pause_zero", {58'd0, ctrl.pause}, 64'd0);
        pause_req = '0;
        tick();

        // Exception behind busy MEM, second exception ignored
        excp_valid = 1; mem_busy = 1; excp_target = 32'h1C00_0180;
        push(cyc + 4, 1'b1, 32'h1C00_0180);
        tick();
        excp_valid = 0; #1;
        chk("fw_pause_1", {58'd0, ctrl.pause}, 64'b111111);
        tick();
        excp_valid = 1; excp_target = 32'h0000_0008; #1;
        chk("fw_pause_2", {58'd0, ctrl.pause}, 64'b111111);
        tick();
        excp_valid = 0; mem_busy = 0; #1;
        chk("fw_pause_3", {58'd0, ctrl.pause}, 64'b111111);
        tick();
        chk("fw_flush_pause", {58'd0, ctrl.pause}, 64'd0);
        tick();

        // Branch and exception together: exception wins
        excp_valid = 1; excp_target = 32'h1C00_0200;
        branch_valid = 1; branch_target = 32'h0000_4000;
        push(cyc + 1, 1'b1, 32'h1C00_0200);
        tick();
        excp_valid = 0; branch_valid = 0;
        tick();

        // Branch blocked by EX stall, then accepted
        branch_valid = 1; branch_target = 32'h0000_8000; pause_req = 6'b010000; #1;
        chk("br_stall_pause", {58'd0, ctrl.pause}, 64'b011111);
        tick();
        pause_req = '0;
        push(cyc + 1, 1'b0, 32'h0000_8000);
        tick();
        branch_valid = 0;
        tick();

        // Idle until interrupt
        idle_valid = 1; irq_pending = 0;
        tick();
        idle_valid = 0; #1;
        chk("idle_pause_0", {58'd0, ctrl.pause}, 64'b111111);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("idle_pause_n", {58'd0, ctrl.pause}, 64'b111111);
        end
        irq_pending = 1; #1;
        chk("idle_irq_same", {58'd0, ctrl.pause}, 64'b111111);
        tick();
        irq_pending = 0; pause_req = 6'b000100; #1;
        chk("idle_resume", {58'd0, ctrl.pause}, 64'b000111);
        pause_req = '0;
        idle_valid = 1; irq_pending = 1;
        tick();
        idle_valid = 0; irq_pending = 0; #1;
        chk("idle_noop", {58'd0, ctrl.pause}, 64'd0);
        tick();

        // Watchdog
        pause_req = 6'b100000;
        repeat (1023) tick();
        chk("wdog_1023", {63'd0, timeout_err}, 64'd0);
        tick();
        chk("wdog_1024", {63'd0, timeout_err}, 64'd1);
        pause_req = '0;
        tick();
        chk("wdog_sticky", {63'd0, timeout_err}, 64'd1);

        // Asynchronous reset during FLUSH_WAIT
        excp_valid = 1; mem_busy = 1; excp_target = 32'h1C00_0300;
        tick();
        excp_valid = 0; #1;
        chk("rfw_pause", {58'd0, ctrl.pause}, 64'b111111);
        tick();
        #2 rst = 1'b0; #1;
        chk("rfw_timeout", {63'd0, timeout_err}, 64'd0);
        chk("rfw_pause0",  {58'd0, ctrl.pause}, 64'd0);
        chk("rfw_redir_v", {63'd0, redirect_valid}, 64'd0);
        mem_busy = 0;
        tick(); tick();
        rst = 1'b1; pause_req = 6'b000010; #1;
        chk("rfw_run", {58'd0, ctrl.pause}, 64'b000011);
        pause_req = '0;
        tick(); tick();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
